// File: rtl/rot_pkg.sv
// Shared encodings for the pipelined rotator/shifter.
// Mode 2'b11 is reserved and behaves as a rotate.
package rot_pkg;

  localparam logic [1:0] ROT_MODE_ROT = 2'b00;
  localparam logic [1:0] ROT_MODE_LSH = 2'b01;
  localparam logic [1:0] ROT_MODE_ASH = 2'b10;

  localparam logic ROT_DIR_RIGHT = 1'b0;
  localparam logic ROT_DIR_LEFT  = 1'b1;

endpackage

// File: rtl/rot_stage.sv
// One combinational log2 step: moves the word by STEP positions when en_i is set.
// Vacated bits come from the opposite end (rotate), zeros, or the MSB (arithmetic right).
module rot_stage
  import rot_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] data_o
);

  logic             is_lsh;
  logic             is_ash;
  logic             is_rot;
  logic [STEP-1:0]  fill_l;
  logic [STEP-1:0]  fill_r;
  logic [WIDTH-1:0] left_v;
  logic [WIDTH-1:0] right_v;

  assign is_lsh = (mode_i == ROT_MODE_LSH);
  assign is_ash = (mode_i == ROT_MODE_ASH);
  assign is_rot = !is_lsh && !is_ash;

  always_comb begin
    fill_l = '0;
    fill_r = '0;
    if (is_rot) begin
      fill_l = data_i[WIDTH-1 -: STEP];
      fill_r = data_i[STEP-1:0];
    end else if (is_ash) begin
      // Arithmetic left is plain logical left, so only the right fill copies the sign.
      fill_r = {STEP{data_i[WIDTH-1]}};
    end
  end

  assign left_v  = {data_i[WIDTH-STEP-1:0], fill_l};
  assign right_v = {fill_r, data_i[WIDTH-1:STEP]};

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      data_o = (dir_i == ROT_DIR_LEFT) ? left_v : right_v;
    end
  end

endmodule

// File: rtl/rot_pipe.sv
// Pipelined barrel rotator/shifter: one log2 stage per cycle behind a valid/ready stream.
// All stages advance together under a single enable; bubbles are kept, not collapsed.
module rot_pipe
  import rot_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_amt,
  input  logic                       in_dir,
  input  logic [1:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       busy
);

  localparam int SHW = $clog2(WIDTH);

  // Control fields are only needed by later stages, so the last register carries data/valid only.
  logic [WIDTH-1:0] data_q  [SHW];
  logic [SHW-1:0]   valid_q;
  logic             dir_q   [SHW-1];
  logic [1:0]       mode_q  [SHW-1];
  logic [SHW-1:0]   amt_q   [SHW-1];

  logic [WIDTH-1:0] st_data [SHW];
  logic             st_dir  [SHW];
  logic [1:0]       st_mode [SHW];
  logic [SHW-1:0]   st_amt  [SHW];
  logic [WIDTH-1:0] st_out  [SHW];

  logic en;

  assign en        = !valid_q[SHW-1] || out_ready;
  assign in_ready  = en;
  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign busy      = |valid_q;

  genvar gi;
  generate
    for (gi = 0; gi < SHW; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign st_data[gi] = in_data;
        assign st_dir[gi]  = in_dir;
        assign st_mode[gi] = in_mode;
        assign st_amt[gi]  = in_amt;
      end else begin : g_rest
        assign st_data[gi] = data_q[gi-1];
        assign st_dir[gi]  = dir_q[gi-1];
        assign st_mode[gi] = mode_q[gi-1];
        assign st_amt[gi]  = amt_q[gi-1];
      end

      rot_stage #(
        .WIDTH (WIDTH),
        .STEP  (1 << gi)
      ) u_stage (
        .data_i (st_data[gi]),
        .en_i   (st_amt[gi][gi]),
        .dir_i  (st_dir[gi]),
        .mode_i (st_mode[gi]),
        .data_o (st_out[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < SHW; i++) begin
        data_q[i] <= '0;
      end
      for (int i = 0; i < SHW - 1; i++) begin
        dir_q[i]  <= ROT_DIR_RIGHT;
        mode_q[i] <= ROT_MODE_ROT;
        amt_q[i]  <= '0;
      end
    end else if (en) begin
      valid_q <= {valid_q[SHW-2:0], in_valid};
      for (int i = 0; i < SHW; i++) begin
        data_q[i] <= st_out[i];
      end
      for (int i = 0; i < SHW - 1; i++) begin
        dir_q[i]  <= st_dir[i];
        mode_q[i] <= st_mode[i];
        amt_q[i]  <= st_amt[i];
      end
    end
  end

endmodule

// File: tb/tb_rot_pipe.sv
// Self-checking bench for rot_pipe (WIDTH=8): directed vectors, stall, random stream, mid-stream reset.
// Expected words come from a word-level rotate/shift model and a FIFO scoreboard.
module tb_rot_pipe;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [2:0] in_amt = 3'd0;
  logic       in_dir = 1'b0;
  logic [1:0] in_mode = 2'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       busy;

  always #5 clk = ~clk;

  rot_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] d;
    int         acc;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic [2:0] a;
    logic       dr;
    logic [1:0] m;
    logic [7:0] x;
  } vec_t;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  bit         lat_chk = 1'b0;
  bit         rnd_rdy = 1'b0;
  exp_t       sb_q[$];
  logic [7:0] out_log[$];
  vec_t       tab[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Word-level model: rotation via a doubled word, shifts via native operators.
  function automatic logic [7:0] ref_rot(input logic [7:0] d, input logic [2:0] a,
                                         input logic dr, input logic [1:0] m);
    int          s;
    logic [7:0]  r;
    logic [15:0] dd;
    s  = int'(a);
    dd = {d, d};
    if (m == 2'd1) begin
      if (dr) r = d << s;
      else    r = d >> s;
    end else if (m == 2'd2) begin
      if (dr) r = d << s;
      else    r = 8'($signed(d) >>> s);
    end else begin
      if (dr) r = dd[15 - s -: 8];
      else    r = dd[s +: 8];
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: sample both handshakes mid-cycle; transfers happen at the following edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("spurious_out", 32'(out_data) | 32'h100, 32'h0);
        end else begin
          e = sb_q.pop_front();
          $display("t=%0t out %02h exp %02h", $time, out_data, e.d);
          check("data", 32'(out_data), 32'(e.d));
          if (lat_chk) check("latency", 32'(cyc - e.acc), 32'd2);
          out_log.push_back(out_data);
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back('{d: ref_rot(in_data, in_amt, in_dir, in_mode), acc: cyc + 1});
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [7:0] d, input logic [2:0] a, input logic dr, input logic [1:0] m);
    int k;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_dir   = dr;
    in_mode  = m;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 100) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_amt   = 3'($urandom);
    in_dir   = 1'($urandom);
    in_mode  = 2'($urandom);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) break;
    end
    check("drain", {31'b0, (sb_q.size() != 0) || busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n0;
    logic [7:0] held;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, back-to-back with out_ready held high
    tab.push_back('{8'h5A, 3'd1, 1'b0, 2'd0, 8'h2D});
    tab.push_back('{8'h81, 3'd3, 1'b1, 2'd0, 8'h0C});
    tab.push_back('{8'h81, 3'd3, 1'b1, 2'd1, 8'h08});
    tab.push_back('{8'h90, 3'd2, 1'b0, 2'd2, 8'hE4});
    tab.push_back('{8'h90, 3'd2, 1'b0, 2'd1, 8'h24});
    tab.push_back('{8'h90, 3'd2, 1'b0, 2'd0, 8'h24});
    tab.push_back('{8'h90, 3'd0, 1'b0, 2'd2, 8'h90});
    tab.push_back('{8'h90, 3'd0, 1'b1, 2'd0, 8'h90});
    tab.push_back('{8'h90, 3'd0, 1'b1, 2'd1, 8'h90});
    tab.push_back('{8'h90, 3'd0, 1'b0, 2'd3, 8'h90});
    for (int k = 0; k < 8; k++) begin
      tab.push_back('{8'h01, 3'(k), 1'b1, 2'd0, 8'(1 << k)});
    end
    lat_chk   = 1'b1;
    out_ready = 1'b1;
    n0 = out_log.size();
    foreach (tab[i]) send(tab[i].d, tab[i].a, tab[i].dr, tab[i].m);
    drain();
    check("dir_count", 32'(out_log.size() - n0), 32'(tab.size()));
    foreach (tab[i]) begin
      if (n0 + i < out_log.size()) check($sformatf("dir_%0d", i), 32'(out_log[n0 + i]), 32'(tab[i].x));
    end

    // Fill the pipeline against a stalled sink, then hold for 5 cycles
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(8'($urandom), 3'($urandom), 1'($urandom), 2'($urandom));
    in_valid = 1'b1;
    in_data  = 8'hC3;
    in_amt   = 3'd5;
    in_dir   = 1'b0;
    in_mode  = 2'd2;
    @(negedge clk);
    held = out_data;
    check("stall_valid_start", 32'(out_valid), 32'd1);
    if (sb_q.size() != 0) check("stall_head", 32'(out_data), 32'(sb_q[0].d));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_hold", 32'(out_data), 32'(held));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // Randomized stream with random backpressure and gaps
    n0 = out_log.size();
    rnd_rdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      send(8'($urandom), 3'($urandom), 1'($urandom), 2'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rnd_rdy = 1'b0;
    #1 out_ready = 1'b1;
    check("rand_count", 32'(out_log.size() - n0), 32'd300);

    // Asynchronous reset with words in flight
    @(posedge clk);
    #1;
    lat_chk = 1'b1;
    for (int k = 0; k < 5; k++) send(8'($urandom), 3'($urandom), 1'($urandom), 2'($urandom));
    check("busy_pre_reset", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    n0 = out_log.size();
    for (int k = 0; k < 4; k++) send(8'($urandom), 3'($urandom), 1'($urandom), 2'($urandom));
    drain();
    check("post_reset_count", 32'(out_log.size() - n0), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rot_pipe.md
# rot_pipe

Parametrised, pipelined barrel shifter/rotator with a valid/ready stream interface. It rotates or shifts a WIDTH-bit word left or right by 0..WIDTH-1 positions, one log2 stage per cycle, and sustains one result per cycle. It replaces fixed-width combinational rotators in the datapath wherever operands arrive as a handshaked stream and the timing path must be cut.

## Interface
- WIDTH, 8, data width; power of two, at least 4.
- SHW, $clog2(WIDTH), derived localparam; width of the shift amount.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the input word this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  SHW  shift/rotate amount, 0..WIDTH-1.
- in_dir  in  1  0 = right, 1 = left.
- in_mode  in  2  00 rotate, 01 logical shift, 10 arithmetic shift, 11 reserved (treated as rotate).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  result.
- busy  out  1  at least one pipeline stage holds a valid word.

## Operation
- SHW stages. Stage i (0 = first) moves the word by 2^i positions when in_amt bit i is 1, otherwise passes it unchanged. Each stage registers data, valid, dir, mode and the remaining amount bits.
- Rotate: bits leaving one end re-enter at the other.
- Logical shift: vacated bits are 0.
- Arithmetic right: vacated bits copy the MSB of the stage input, which preserves the original sign through all stages. Arithmetic left is identical to logical left.
- Amount 0: out_data equals in_data for every mode and direction.
- Global advance enable: en = !out_valid || out_ready. All stages shift forward together when en is 1 and hold when en is 0.
- in_ready = en. This is a combinational path from out_ready to in_ready. Bubbles are not collapsed.
- A transfer occurs on any edge where valid && ready on that side. Words leave in acceptance order; none are lost or duplicated.
- busy = OR of all stage valid bits, including the output stage.

## Timing
- Latency is SHW cycles. A word accepted at edge t has out_valid high after edge t+SHW-1, so it is visible in the cycle following that edge, provided en stays 1 throughout.
- Throughput is 1 word/cycle when out_ready is held at 1.
- While out_valid=1 and out_ready=0:
  - out_data and out_valid are held stable.
  - in_ready=0.
  - No internal state changes.
- Simultaneous accept and emit in the same cycle is legal and required for full throughput.
- Reset, asynchronous and possible at any point including mid-stream:
  - All stage valid bits clear immediately.
  - out_valid=0, busy=0, out_data=0, in_ready=1.
  - In-flight words are discarded.
  - The first edge after deassertion may accept a word.
- in_data, in_amt, in_dir and in_mode are sampled only on an accepting edge. Values present when in_valid=0 are ignored.

## Structure
- Package rot_pkg holds:
  - Mode constants ROT_MODE_ROT, ROT_MODE_LSH, ROT_MODE_ASH.
  - Direction constants ROT_DIR_RIGHT, ROT_DIR_LEFT.
  - Nothing WIDTH-dependent.
- Sub-module rot_stage (parameters WIDTH, STEP): combinational move of one stage by STEP positions, selected by enable, dir and mode. It is instantiated SHW times in a generate loop with STEP = 2^i. The pipeline registers live in rot_pipe.

## Test plan
All scenarios use WIDTH=8, so SHW=3 and latency is 3.
- Rotate right, 0x5A, amt 1, out_ready=1 → 0x2D, out_valid exactly 3 cycles after accept.
- Rotate left, 0x81, amt 3 → 0x0C. Same operand with logical left → 0x08.
- Right shift of 0x90 by amt 2: arithmetic → 0xE4, logical → 0x24, rotate → 0x24. Amt 0 in any mode → 0x90.
- Stream 0x01 rotate-left with amt 0..7 on consecutive cycles, out_ready=1 → 0x01, 0x02, …, 0x80 on consecutive cycles, in order, starting 3 cycles after the first accept.
- Full pipeline, then out_ready=0 for 5 cycles → in_ready=0, out_data stable. After release, every word emerges exactly once and in order.
- rst_n pulsed low mid-stream, asynchronous to clk → out_valid=0, busy=0, out_data=0 before the next edge. No stale word appears after reset.
